// File: rtl/lsu.sv
// Load/store unit: one word-aligned req/ack memory transaction per access,
// with lane steering, load extension, alignment faults and an ack timeout.
module lsu #(
  parameter int WORDSIZE = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic                WE,
  input  logic [2:0]          FUNCT3,
  input  logic [WORDSIZE-1:0] ADDR,
  input  logic [WORDSIZE-1:0] WDATA,
  output logic                BUSY,
  output logic                DONE,
  output logic [WORDSIZE-1:0] RDATA,
  output logic                MISALIGN,
  output logic                TIMEOUT_ERR,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [WORDSIZE-1:0] MEM_ADDR,
  output logic [3:0]          MEM_BE,
  output logic [WORDSIZE-1:0] MEM_WDATA,
  input  logic                MEM_ACK,
  input  logic [WORDSIZE-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [2:0]          f3_r;
  logic [1:0]          off_r;
  logic                we_r, mis_r, tmo_r;
  logic [7:0]          cnt;
  logic                legal;
  logic [3:0]          be;
  logic [WORDSIZE-1:0] wd, sh, ld;

  // Request decode straight from the inputs; only consumed in IDLE
  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    wd    = '0;
    case (FUNCT3[1:0])
      2'b00: begin
        legal = 1'b1;
        be    = 4'b0001 << ADDR[1:0];
        wd    = {{(WORDSIZE-8){1'b0}}, WDATA[7:0]} << {ADDR[1:0], 3'b000};
      end
      2'b01: begin
        legal = ~ADDR[0];
        be    = 4'b0011 << ADDR[1:0];
        wd    = {{(WORDSIZE-16){1'b0}}, WDATA[15:0]} << {ADDR[1:0], 3'b000};
      end
      2'b10: begin
        legal = (ADDR[1:0] == 2'b00);
        be    = 4'b1111;
        wd    = WDATA;
      end
      default: legal = 1'b0;
    endcase
    // Unsigned variants exist only for byte/half loads
    if (FUNCT3[2] && (WE || FUNCT3[1])) legal = 1'b0;
  end

  always_comb begin
    sh = MEM_RDATA >> {off_r, 3'b000};
    case (f3_r)
      3'b000:  ld = {{(WORDSIZE-8){sh[7]}}, sh[7:0]};
      3'b100:  ld = {{(WORDSIZE-8){1'b0}}, sh[7:0]};
      3'b001:  ld = {{(WORDSIZE-16){sh[15]}}, sh[15:0]};
      3'b101:  ld = {{(WORDSIZE-16){1'b0}}, sh[15:0]};
      default: ld = sh;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (START) state_nxt = legal ? REQ : RESP;
      REQ:  if (MEM_ACK || cnt == LAST) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      f3_r      <= '0;
      off_r     <= '0;
      we_r      <= 1'b0;
      mis_r     <= 1'b0;
      tmo_r     <= 1'b0;
      cnt       <= '0;
      RDATA     <= '0;
      MEM_ADDR  <= '0;
      MEM_BE    <= '0;
      MEM_WDATA <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (START) begin
          we_r      <= WE;
          f3_r      <= FUNCT3;
          off_r     <= ADDR[1:0];
          mis_r     <= ~legal;
          tmo_r     <= 1'b0;
          cnt       <= '0;
          MEM_ADDR  <= {ADDR[WORDSIZE-1:2], 2'b00};
          MEM_BE    <= be;
          MEM_WDATA <= wd;
        end
        REQ: begin
          // An ack in the final wait cycle takes priority over the timeout
          if (MEM_ACK) begin
            if (!we_r) RDATA <= ld;
          end else if (cnt == LAST) begin
            tmo_r <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY        = (state != IDLE);
  assign DONE        = (state == RESP);
  assign MEM_REQ     = (state == REQ);
  assign MEM_WE      = we_r;
  assign MISALIGN    = DONE & mis_r;
  assign TIMEOUT_ERR = DONE & tmo_r;

endmodule
